// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus scheduler.
// Contents: SPART register address encodings, scheduler state enumeration,
// and the baud divisor loaded after reset. 325 selects 9600 baud.
package spart_pkg;

    localparam logic [1:0] IOADDR_DATA   = 2'b00;
    localparam logic [1:0] IOADDR_STATUS = 2'b01;
    localparam logic [1:0] IOADDR_DB_LO  = 2'b10;
    localparam logic [1:0] IOADDR_DB_HI  = 2'b11;

    localparam logic [15:0] SPART_DEFAULT_DIVISOR = 16'd325;

    typedef enum logic [2:0] {
        ST_CFG_LO,
        ST_CFG_HI,
        ST_IDLE,
        ST_RX,
        ST_TX
    } sched_state_t;

endpackage

// File: rtl/spart_txq.sv
// Synchronous FIFO that holds the TX words waiting to go out to the SPART.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (empties the queue)
//   i_push, i_din  write strobe and data; a push while full is dropped
//   i_pop          removes the head word; a pop while empty is dropped
//   o_dout         head word (valid while o_count != 0)
//   o_count        occupancy, 0..DEPTH
module spart_txq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !w_empty;

    // Storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/spart_bus_sched.sv
// SPART bus scheduler: programs the baud divisor, moves received byte pairs
// into 16-bit words and sends queued 16-bit words as two bytes, low first.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   cfg_divisor, cfg_load            runtime divisor reprogramming request
//   tx_word, tx_word_valid/_ready    TX word queue input handshake
//   rx_word, rx_word_valid           assembled RX word and its one-cycle strobe
//   rda, tbr                         SPART receive-available / transmit-ready
//   iocs, iorw, ioaddr               SPART bus access control
//   db_out, db_oe, db_in             SPART data bus (split)
//   rx_word_cnt, tx_word_cnt         wrapping word counters
//   cfg_busy                         divisor programming in progress
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_CFG_LO | write divisor low byte to DB low (held here during reset)
// ST_CFG_HI | write divisor high byte to DB high
// ST_IDLE   | status address on the bus, arbitrate cfg / RX / TX
// ST_RX     | read one byte from the SPART data register
// ST_TX     | write one byte of the queue head to the SPART data register
module spart_bus_sched
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIVISOR = SPART_DEFAULT_DIVISOR,
    parameter int          TXQ_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_divisor,
    input  logic        cfg_load,
    input  logic [15:0] tx_word,
    input  logic        tx_word_valid,
    output logic        tx_word_ready,
    output logic [15:0] rx_word,
    output logic        rx_word_valid,
    input  logic        rda,
    input  logic        tbr,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    output logic [7:0]  db_out,
    output logic        db_oe,
    input  logic [7:0]  db_in,
    output logic [11:0] rx_word_cnt,
    output logic [11:0] tx_word_cnt,
    output logic        cfg_busy
);

    localparam int QCW = $clog2(TXQ_DEPTH) + 1;

    sched_state_t   r_state;
    sched_state_t   w_next;

    logic           r_run;
    logic [15:0]    r_divisor;
    logic [15:0]    r_div_new;
    logic           r_cfg_pend;
    logic           r_tbr_d;
    logic           r_tx_hold;
    logic           r_last_tx;
    logic           r_tx_phase;
    logic           r_rx_phase;
    logic           r_rx_valid;
    logic [15:0]    r_rx_word;
    logic [11:0]    r_rx_cnt;
    logic [11:0]    r_tx_cnt;

    logic [15:0]    w_q_head;
    logic [QCW-1:0] w_q_count;
    logic           w_q_full;
    logic           w_q_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_rx_elig;
    logic           w_tx_elig;
    logic           w_cfg_start;

    assign w_q_full      = (w_q_count == QCW'(TXQ_DEPTH));
    assign w_q_empty     = (w_q_count == '0);
    // r_run is low only during reset and its release cycle, which keeps
    // tx_word_ready low while reset is asserted.
    assign tx_word_ready = r_run && !w_q_full;
    assign w_push        = tx_word_valid && tx_word_ready;
    assign w_pop         = (r_state == ST_TX) && r_tx_phase;
    assign w_rx_elig     = rda;
    assign w_tx_elig     = !w_q_empty && tbr && !r_tx_hold;
    assign w_cfg_start   = (r_state == ST_IDLE) && (w_next == ST_CFG_LO);

    spart_txq #(
        .DEPTH (TXQ_DEPTH),
        .WIDTH (16)
    ) u_txq (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (tx_word),
        .i_pop   (w_pop),
        .o_dout  (w_q_head),
        .o_count (w_q_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_CFG_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            // Wait here for the first cycle after reset release so the
            // low-byte write is actually presented on the bus.
            ST_CFG_LO: w_next = r_run ? ST_CFG_HI : ST_CFG_LO;
            ST_CFG_HI: w_next = ST_IDLE;
            ST_IDLE: begin
                if (r_cfg_pend) begin
                    w_next = ST_CFG_LO;
                end else if (w_rx_elig && w_tx_elig) begin
                    w_next = r_last_tx ? ST_RX : ST_TX;
                end else if (w_rx_elig) begin
                    w_next = ST_RX;
                end else if (w_tx_elig) begin
                    w_next = ST_TX;
                end
            end
            ST_RX:     w_next = ST_IDLE;
            ST_TX:     w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        iocs     = 1'b0;
        iorw     = 1'b1;
        ioaddr   = IOADDR_STATUS;
        db_oe    = 1'b0;
        db_out   = 8'h00;
        cfg_busy = 1'b0;
        case (r_state)
            ST_CFG_LO: begin
                if (r_run) begin
                    iocs     = 1'b1;
                    iorw     = 1'b0;
                    ioaddr   = IOADDR_DB_LO;
                    db_oe    = 1'b1;
                    db_out   = r_divisor[7:0];
                    cfg_busy = 1'b1;
                end
            end
            ST_CFG_HI: begin
                iocs     = 1'b1;
                iorw     = 1'b0;
                ioaddr   = IOADDR_DB_HI;
                db_oe    = 1'b1;
                db_out   = r_divisor[15:8];
                cfg_busy = 1'b1;
            end
            ST_RX: begin
                iocs   = 1'b1;
                iorw   = 1'b1;
                ioaddr = IOADDR_DATA;
            end
            ST_TX: begin
                iocs   = 1'b1;
                iorw   = 1'b0;
                ioaddr = IOADDR_DATA;
                db_oe  = 1'b1;
                db_out = r_tx_phase ? w_q_head[15:8] : w_q_head[7:0];
            end
            default: ;
        endcase
    end

    // Divisor staging: a new request lands in r_div_new and is copied into
    // r_divisor only as the CFG sequence starts, so a request arriving in
    // the middle of a CFG pair never mixes bytes of two divisors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_divisor  <= DEFAULT_DIVISOR;
            r_div_new  <= DEFAULT_DIVISOR;
            r_cfg_pend <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_cfg_start) begin
                r_divisor <= r_div_new;
            end
            if (cfg_load) begin
                r_div_new  <= cfg_divisor;
                r_cfg_pend <= 1'b1;
            end else if (w_cfg_start) begin
                r_cfg_pend <= 1'b0;
            end
        end
    end

    // TX pacing and arbitration history. A TX write sets the hold even if
    // tbr happens to rise in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tbr_d    <= 1'b0;
            r_tx_hold  <= 1'b0;
            r_last_tx  <= 1'b1;
            r_tx_phase <= 1'b0;
            r_tx_cnt   <= 12'd0;
        end else begin
            r_tbr_d <= tbr;
            if (r_state == ST_TX) begin
                r_tx_hold <= 1'b1;
            end else if (tbr && !r_tbr_d) begin
                r_tx_hold <= 1'b0;
            end
            if (r_state == ST_RX) begin
                r_last_tx <= 1'b0;
            end else if (r_state == ST_TX) begin
                r_last_tx <= 1'b1;
            end
            if (r_state == ST_TX) begin
                r_tx_phase <= !r_tx_phase;
            end
            if (w_pop) begin
                r_tx_cnt <= r_tx_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_phase <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_word  <= 16'h0000;
            r_rx_cnt   <= 12'd0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state == ST_RX) begin
                if (!r_rx_phase) begin
                    r_rx_word[7:0] <= db_in;
                    r_rx_phase     <= 1'b1;
                end else begin
                    r_rx_word[15:8] <= db_in;
                    r_rx_phase      <= 1'b0;
                    r_rx_valid      <= 1'b1;
                    r_rx_cnt        <= r_rx_cnt + 12'd1;
                end
            end
        end
    end

    assign rx_word       = r_rx_word;
    assign rx_word_valid = r_rx_valid;
    assign rx_word_cnt   = r_rx_cnt;
    assign tx_word_cnt   = r_tx_cnt;

endmodule
